// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v;
    logic              skid_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              accept;
    logic              pop;

    assign accept    = in_valid & in_ready;
    assign pop       = main_v & out_ready;
    assign out_valid = main_v;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    generate
        if (SKID != 0) begin : g_skid
            // State bits are {skid_v, main_v}; 2'b10 is unreachable.
            typedef enum logic [1:0] {
                EMPTY = 2'b00,
                ONE   = 2'b01,
                FULL  = 2'b11
            } state_t;

            state_t            state_q;
            state_t            state_d;
            logic              load_main;
            logic              load_skid;
            logic              skid_to_main;
            logic              clr_main;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            assign main_v   = state_q[0];
            assign skid_v   = state_q[1];
            assign in_ready = ~state_q[1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            always_comb begin
                state_d      = state_q;
                load_main    = 1'b0;
                load_skid    = 1'b0;
                skid_to_main = 1'b0;
                clr_main     = 1'b0;
                unique case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_d   = ONE;
                            load_main = 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            load_main = 1'b1;
                        end else if (accept) begin
                            state_d   = FULL;
                            load_skid = 1'b1;
                        end else if (pop) begin
                            state_d  = EMPTY;
                            clr_main = 1'b1;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state_d      = ONE;
                            skid_to_main = 1'b1;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                if (flush) begin
                    state_d      = EMPTY;
                    load_main    = 1'b0;
                    load_skid    = 1'b0;
                    skid_to_main = 1'b0;
                    clr_main     = 1'b0;
                end
            end

            // Ctrl registers are zeroed whenever their entry empties,
            // so out_ctrl needs no output masking.
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_ctrl <= '0;
                    main_data <= '0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end else if (flush) begin
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                end else begin
                    if (load_main) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (skid_to_main) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                    end else if (clr_main) begin
                        main_ctrl <= '0;
                    end
                    if (load_skid) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end
                end
            end
        end else begin : g_single
            logic main_v_q;

            assign main_v   = main_v_q;
            assign skid_v   = 1'b0;
            assign in_ready = ~main_v_q | out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_v_q  <= 1'b0;
                    main_ctrl <= '0;
                    main_data <= '0;
                end else if (flush) begin
                    main_v_q  <= 1'b0;
                    main_ctrl <= '0;
                end else if (accept) begin
                    main_v_q  <= 1'b1;
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end else if (pop) begin
                    main_v_q  <= 1'b0;
                    main_ctrl <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the skid build (dut a)
// and the single-register build (dut b).
module tb_pipe_stage_reg;

    localparam int DW = 69;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;

    logic          a_in_valid, a_in_ready, a_flush;
    logic          a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;

    logic          b_in_valid, b_in_ready, b_flush;
    logic          b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_ctrl = 4'hf; a_in_data = 69'h1_2345_6789;
        b_in_valid = 1'b1; b_in_ctrl = 4'hf; b_in_data = 69'h1_2345_6789;
        a_flush = 1'b0; b_flush = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_out_valid, a_out_ctrl, a_occ} !== 7'd0 || a_out_data !== '0) begin
            errors++;
            $display("FAIL reset_a: v=%b c=%h d=%h occ=%0d, want all 0",
                     a_out_valid, a_out_ctrl, a_out_data, a_occ);
        end
        checks++;
        if ({b_out_valid, b_out_ctrl, b_occ} !== 7'd0 || b_out_data !== '0) begin
            errors++;
            $display("FAIL reset_b: v=%b c=%h d=%h occ=%0d, want all 0",
                     b_out_valid, b_out_ctrl, b_out_data, b_occ);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: a_rdy=%b b_rdy=%b a_v=%b, want 1 1 0",
                     a_in_ready, b_in_ready, a_out_valid);
        end
    endtask

    task automatic test_streaming();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_ctrl  = i[3:0];
            a_in_data  = DW'(i);
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %b want 1", i, a_in_ready);
            end
            tick();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== DW'(i) ||
                a_out_ctrl !== i[3:0]) begin
                errors++;
                $display("FAIL stream_out[%0d]: v=%b d=%0d c=%h want 1 %0d %h",
                         i, a_out_valid, a_out_data, a_out_ctrl, i, i[3:0]);
            end
        end
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'h0 || a_occ !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: v=%b c=%h occ=%0d want 0 0 0",
                     a_out_valid, a_out_ctrl, a_occ);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1; a_in_ctrl = 4'h1; a_in_data = 69'd10;
        tick();
        a_out_ready = 1'b0;
        a_in_data   = 69'd11;
        tick();
        checks++;
        if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 69'd10) begin
            errors++;
            $display("FAIL bp_full: occ=%0d rdy=%b d=%0d want 2 0 10",
                     a_occ, a_in_ready, a_out_data);
        end
        a_in_data = 69'd12;
        tick();
        checks++;
        if (a_occ !== 2'd2 || a_out_data !== 69'd10 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: occ=%0d d=%0d v=%b want 2 10 1",
                     a_occ, a_out_data, a_out_valid);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_data !== 69'd11 || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1: d=%0d occ=%0d rdy=%b want 11 1 1",
                     a_out_data, a_occ, a_in_ready);
        end
        tick();
        checks++;
        if (a_out_data !== 69'd12 || a_occ !== 2'd1 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop2: d=%0d occ=%0d v=%b want 12 1 1",
                     a_out_data, a_occ, a_out_valid);
        end
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            errors++;
            $display("FAIL bp_drain: v=%b occ=%0d want 0 0", a_out_valid, a_occ);
        end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_ctrl = 4'b1011; a_in_data = 69'd20;
        tick();
        a_in_data = 69'd21;
        tick();
        checks++;
        if (a_occ !== 2'd2) begin
            errors++;
            $display("FAIL flush_fill: occ=%0d want 2", a_occ);
        end
        a_in_data = 69'd22;
        a_flush   = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'h0 || a_occ !== 2'd0 ||
            a_in_ready !== 1'b1 || a_out_data !== 69'd20) begin
            errors++;
            $display("FAIL flush_full: v=%b c=%h occ=%0d rdy=%b d=%0d want 0 0 0 1 20",
                     a_out_valid, a_out_ctrl, a_occ, a_in_ready, a_out_data);
        end
        a_in_data = 69'd23;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            errors++;
            $display("FAIL flush_empty_drop: v=%b occ=%0d want 0 0", a_out_valid, a_occ);
        end
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'h0) begin
            errors++;
            $display("FAIL flush_after: v=%b c=%h want 0 0", a_out_valid, a_out_ctrl);
        end
    endtask

    task automatic test_bubble();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1; a_in_ctrl = 4'b1111; a_in_data = 69'd30;
        tick();
        checks++;
        if (a_out_ctrl !== 4'b1111 || a_out_data !== 69'd30) begin
            errors++;
            $display("FAIL bubble_first: c=%h d=%0d want f 30", a_out_ctrl, a_out_data);
        end
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 4'h0 || a_out_data !== 69'd30) begin
            errors++;
            $display("FAIL bubble_gap: v=%b c=%h d=%0d want 0 0 30",
                     a_out_valid, a_out_ctrl, a_out_data);
        end
        a_in_valid = 1'b1; a_in_data = 69'd31;
        tick();
        checks++;
        if (a_out_ctrl !== 4'b1111 || a_out_data !== 69'd31 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bubble_second: c=%h d=%0d v=%b want f 31 1",
                     a_out_ctrl, a_out_data, a_out_valid);
        end
        a_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_full();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_ctrl = 4'h6; a_in_data = 69'd40;
        tick();
        a_in_data = 69'd41;
        tick();
        rst = 1'b1;
        a_in_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== '0 ||
            a_out_ctrl !== 4'h0) begin
            errors++;
            $display("FAIL reset_full: v=%b occ=%0d d=%0d c=%h want 0 0 0 0",
                     a_out_valid, a_occ, a_out_data, a_out_ctrl);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_full_after: v=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_skid0();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1; b_in_ctrl = 4'h3; b_in_data = 69'h55;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid0_empty_ready: got %b want 1", b_in_ready);
        end
        tick();
        b_in_valid = 1'b0;
        #1;
        checks++;
        if (b_in_ready !== 1'b0 || b_out_data !== 69'h55 || b_occ !== 2'd1) begin
            errors++;
            $display("FAIL skid0_stall: rdy=%b d=%h occ=%0d want 0 55 1",
                     b_in_ready, b_out_data, b_occ);
        end
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1; b_in_ctrl = 4'h5; b_in_data = 69'h66;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid0_comb_ready: got %b want 1", b_in_ready);
        end
        tick();
        checks++;
        if (b_out_data !== 69'h66 || b_occ !== 2'd1 || b_out_valid !== 1'b1 ||
            b_out_ctrl !== 4'h5) begin
            errors++;
            $display("FAIL skid0_swap: d=%h occ=%0d v=%b c=%h want 66 1 1 5",
                     b_out_data, b_occ, b_out_valid, b_out_ctrl);
        end
        b_in_valid = 1'b0;
        tick();
        checks++;
        if (b_out_valid !== 1'b0 || b_out_ctrl !== 4'h0 || b_occ !== 2'd0) begin
            errors++;
            $display("FAIL skid0_drain: v=%b c=%h occ=%0d want 0 0 0",
                     b_out_valid, b_out_ctrl, b_occ);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_reset_full();
        test_skid0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, downstream stall, synchronous flush and an optional two-entry skid buffer. It replaces the fixed-width, always-advancing inter-stage latches between ID/EX, EX/MEM and MEM/WB with one block that carries a control field and a data payload. It also guarantees that a bubble presents all-zero control to the next stage.

## Interface
- DATA_W, 69: payload width in bits; 69 is the EX/MEM default of alu result 32 + store data 32 + rd 5.
- CTRL_W, 4: control field width in bits; the default holds wb[1:0] and mem_read/mem_write.
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  control field of the incoming beat.
- in_data  in  DATA_W  payload of the incoming beat.
- flush  in  1  synchronous kill of all held beats and of the incoming beat.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_ctrl  out  CTRL_W  control field; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  payload; holds its last value when out_valid=0.
- occupancy  out  2  number of held beats: 0, 1 or 2.

## Operation
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Storage:
  - main register (main_v, main_ctrl, main_data) drives the outputs directly.
  - skid register (skid_v, skid_ctrl, skid_data) exists only when SKID=1.
- Priority order: rst, then flush, then the handshake.
- rst: main_v=0, skid_v=0, all ctrl and data registers cleared to 0.
- flush: main_v=0, skid_v=0, ctrl registers cleared to 0.
  - Data registers hold their values.
  - A beat offered in the flush cycle is dropped, even if in_ready=1.
- SKID=1 state machine, encoded by {skid_v, main_v}:
  - EMPTY: accept moves to ONE and loads main.
  - ONE with accept & pop: stays ONE and loads main with the new beat.
  - ONE with accept & !pop: moves to FULL and loads skid.
  - ONE with !accept & pop: moves to EMPTY.
  - ONE with neither: holds.
  - FULL with pop: moves to ONE; main <= skid.
  - FULL with !pop: holds.
  - in_ready = !skid_v, a direct register output with no combinational path from out_ready.
- SKID=0:
  - in_ready = !main_v | out_ready.
  - Accept loads main. Pop without accept clears main_v.
- Ordering is strictly FIFO; no beat is ever duplicated or reordered.
- occupancy = main_v + skid_v.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 in the cycle after reset is released.
  - With SKID=0, in_ready=1 is already true during reset, but beats are ignored while rst=1.
- Latency: a beat accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: one beat per cycle while out_ready=1, in both modes.
- Backpressure with SKID=1: one extra beat is absorbed after out_ready falls. in_ready falls in the cycle after the skid register fills.
- Simultaneous accept and pop while FULL is impossible because in_ready=0.
- Flush has effect at the edge. In the following cycle out_valid=0, out_ctrl=0, occupancy=0 and in_ready=1.
- Reset mid-stream with FULL occupancy behaves like flush, and additionally zeroes the data registers.
- out_ctrl is gated by main_v at the register, not by combinational masking, so it is glitch-free.

## Test plan
- Reset: assert rst for 2 cycles while in_valid=1 and in_data=0x1_2345_6789 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- Streaming (SKID=1, out_ready=1): push beats with data 1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, starting one cycle after the first accept, with in_ready constantly 1.
- Backpressure: stream data 10, 11, 12; drop out_ready after 10 is visible -> occupancy=2 and in_ready=0 with 10 in main and 11 in skid; 12 is held upstream. Raise out_ready -> outputs 10, 11, 12 in order with no loss.
- Flush while FULL: ctrl=4'b1011 on both entries, assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the offered beat never appears on the outputs.
- Bubble control: idle for one cycle between two beats with ctrl=4'b1111 -> out_ctrl=0 during the gap cycle.
- SKID=0 build: out_ready=0 while main holds data 0x55 -> in_ready=0. Raise out_ready together with in_valid (data 0x66) -> same-cycle accept and pop; out_data=0x66 next cycle, occupancy=1.
